// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - control, data and status bundle for universal_shift_reg
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] load_data;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             ser_out_l;
  logic             ser_out_r;

  modport master (
    output start, op, count, load_data, ser_in_l, ser_in_r,
    input  q, busy, done, ser_out_l, ser_out_r
  );

  modport slave (
    input  start, op, count, load_data, ser_in_l, ser_in_r,
    output q, busy, done, ser_out_l, ser_out_r
  );
endinterface

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - multi-step shift/rotate/load register, one bit step per cycle
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  universal_shift_reg_if.slave bus
);
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ASR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic             w_is_shift;

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v,
                                              input logic [2:0]       o,
                                              input logic             sl,
                                              input logic             sr);
    case (o)
      OP_SHR:  f_step = {sl, v[WIDTH-1:1]};
      OP_SHL:  f_step = {v[WIDTH-2:0], sr};
      OP_ROR:  f_step = {v[0], v[WIDTH-1:1]};
      OP_ROL:  f_step = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  f_step = {v[WIDTH-1], v[WIDTH-1:1]};
      default: f_step = v;
    endcase
  endfunction

  assign w_is_shift = (bus.op >= OP_SHR) && (bus.op <= OP_ASR);

  always_comb begin
    w_state_nxt     = r_state;
    w_q_nxt         = r_q;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_op_nxt        = r_op;
    w_remaining_nxt = r_remaining;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_op_nxt = bus.op;
          if (bus.op == OP_LOAD) begin
            w_q_nxt    = bus.load_data;
            w_done_nxt = 1'b1;
          end else if (w_is_shift && bus.count != '0) begin
            // First step happens on the accept edge itself.
            w_q_nxt = f_step(r_q, bus.op, bus.ser_in_l, bus.ser_in_r);
            if (bus.count == CNT_W'(1)) begin
              w_done_nxt = 1'b1;
            end else begin
              w_busy_nxt      = 1'b1;
              w_state_nxt     = RUN;
              w_remaining_nxt = bus.count - CNT_W'(1);
            end
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        w_q_nxt = f_step(r_q, r_op, bus.ser_in_l, bus.ser_in_r);
        if (r_remaining == CNT_W'(1)) begin
          w_done_nxt      = 1'b1;
          w_state_nxt     = IDLE;
          w_remaining_nxt = '0;
        end else begin
          w_busy_nxt      = 1'b1;
          w_remaining_nxt = r_remaining - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_op        <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_q         <= w_q_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_op        <= w_op_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  assign bus.q         = r_q;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ser_out_l = r_q[WIDTH-1];
  assign bus.ser_out_r = r_q[0];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - vector table, hand sequences and randomized model check
module tb_universal_shift_reg;
  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  universal_shift_reg_if #(.WIDTH(W), .CNT_W(C)) bus ();

  universal_shift_reg #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] init;
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] ld;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_apply(input logic [7:0] q, input logic [2:0] op,
                                         input int n, input logic [7:0] ld,
                                         input logic sl, input logic sr);
    logic [15:0] d;
    logic [7:0]  fl, fr;
    d  = {q, q};
    fl = {8{sl}};
    fr = {8{sr}};
    case (op)
      3'd1: m_apply = (n >= 8) ? fl : 8'((q >> n) | (fl << (8 - n)));
      3'd2: m_apply = (n >= 8) ? fr : 8'((q << n) | (fr >> (8 - n)));
      3'd3: m_apply = 8'(d >> (n % 8));
      3'd4: m_apply = 8'((d << (n % 8)) >> 8);
      3'd5: m_apply = 8'($signed(q) >>> n);
      3'd6: m_apply = ld;
      default: m_apply = q;
    endcase
  endfunction

  function automatic int m_lat(input logic [2:0] op, input int n);
    m_lat = (op >= 3'd1 && op <= 3'd5 && n > 1) ? n : 1;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] ld,
                        input logic sl, input logic sr,
                        output logic [7:0] q_out, output int lat, output int busy_cyc);
    @(negedge clk);
    bus.op = op; bus.count = cnt; bus.load_data = ld;
    bus.ser_in_l = sl; bus.ser_in_r = sr; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1 lat++;
    end
    chk("busy_done_exclusive", bus.busy, 0);
    q_out = bus.q;
    @(posedge clk);
    #1 chk("done_one_cycle", bus.done, 0);
  endtask

  vec_t        vecs[12];
  logic [7:0]  q_got, mq, exp_q;
  int          lat, bcyc;
  logic        seen_done;
  logic [7:0]  trace_q[3];
  logic        trace_b[3], trace_d[3];

  initial begin
    bus.start = 0; bus.op = 0; bus.count = 0; bus.load_data = 0;
    bus.ser_in_l = 0; bus.ser_in_r = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", bus.q, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    @(negedge clk) reset = 1'b0;

    vecs[0]  = '{8'hA5, 3'd1, 4'd3,  8'h00, 1'b1, 1'b0, 8'hF4, 3};
    vecs[1]  = '{8'h81, 3'd4, 4'd8,  8'h00, 1'b0, 1'b0, 8'h81, 8};
    vecs[2]  = '{8'h90, 3'd5, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE4, 2};
    vecs[3]  = '{8'h01, 3'd2, 4'd15, 8'h00, 1'b0, 1'b0, 8'h00, 15};
    vecs[4]  = '{8'h3C, 3'd2, 4'd0,  8'h00, 1'b0, 1'b1, 8'h3C, 1};
    vecs[5]  = '{8'h3C, 3'd7, 4'd5,  8'h00, 1'b1, 1'b1, 8'h3C, 1};
    vecs[6]  = '{8'h5A, 3'd3, 4'd1,  8'h00, 1'b0, 1'b0, 8'h2D, 1};
    vecs[7]  = '{8'h80, 3'd2, 4'd9,  8'h00, 1'b0, 1'b1, 8'hFF, 9};
    vecs[8]  = '{8'h5A, 3'd0, 4'd3,  8'h00, 1'b1, 1'b1, 8'h5A, 1};
    vecs[9]  = '{8'h0F, 3'd3, 4'd12, 8'h00, 1'b0, 1'b0, 8'hF0, 12};
    vecs[10] = '{8'hC3, 3'd6, 4'd7,  8'h42, 1'b0, 1'b0, 8'h42, 1};
    vecs[11] = '{8'hFF, 3'd1, 4'd10, 8'h00, 1'b0, 1'b0, 8'h00, 10};

    for (int i = 0; i < 12; i++) begin
      run_op(3'd6, 4'd0, vecs[i].init, 1'b0, 1'b0, q_got, lat, bcyc);
      run_op(vecs[i].op, vecs[i].cnt, vecs[i].ld, vecs[i].sl, vecs[i].sr, q_got, lat, bcyc);
      chk($sformatf("vec%0d_q", i), q_got, vecs[i].exp_q);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].exp_lat - 1);
    end

    // SHR 3 from A5 with fill 1: per-edge trace
    run_op(3'd6, 4'd0, 8'hA5, 1'b0, 1'b0, q_got, lat, bcyc);
    trace_q = '{8'hD2, 8'hE9, 8'hF4};
    trace_b = '{1'b1, 1'b1, 1'b0};
    trace_d = '{1'b0, 1'b0, 1'b1};
    @(negedge clk);
    bus.op = 3'd1; bus.count = 4'd3; bus.ser_in_l = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk($sformatf("trace%0d_q", i), bus.q, trace_q[i]);
      chk($sformatf("trace%0d_busy", i), bus.busy, trace_b[i]);
      chk($sformatf("trace%0d_done", i), bus.done, trace_d[i]);
    end
    @(posedge clk);
    #1 chk("trace_done_drop", bus.done, 0);

    // fill bit sampled live on every shift edge
    run_op(3'd6, 4'd0, 8'h00, 1'b0, 1'b0, q_got, lat, bcyc);
    @(negedge clk);
    bus.op = 3'd1; bus.count = 4'd2; bus.ser_in_l = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("live_step1", bus.q, 8'h80);
    bus.ser_in_l = 1'b0;
    @(posedge clk);
    #1 chk("live_step2", bus.q, 8'h40);
    chk("live_done", bus.done, 1);
    @(posedge clk);

    // start during busy is ignored; start in the done cycle is accepted
    run_op(3'd6, 4'd0, 8'hF0, 1'b0, 1'b0, q_got, lat, bcyc);
    @(negedge clk);
    bus.op = 3'd1; bus.count = 4'd4; bus.ser_in_l = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 chk("ign_step1", bus.q, 8'h78);
    bus.op = 3'd6; bus.load_data = 8'h00;
    @(posedge clk);
    #1 chk("ign_step2", bus.q, 8'h3C);
    chk("ign_busy", bus.busy, 1);
    @(posedge clk);
    #1 chk("ign_step3", bus.q, 8'h1E);
    @(posedge clk);
    #1 chk("ign_step4", bus.q, 8'h0F);
    chk("ign_done", bus.done, 1);
    bus.load_data = 8'h3C;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("b2b_q", bus.q, 8'h3C);
    chk("b2b_done", bus.done, 1);
    chk("b2b_busy", bus.busy, 0);
    @(posedge clk);
    #1 chk("b2b_done_drop", bus.done, 0);

    // asynchronous reset in the middle of a run
    run_op(3'd6, 4'd0, 8'hFF, 1'b0, 1'b0, q_got, lat, bcyc);
    @(negedge clk);
    bus.op = 3'd1; bus.count = 4'd9; bus.ser_in_l = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_q", bus.q, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    @(negedge clk) reset = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen_done = seen_done | bus.done;
    end
    chk("postreset_q", bus.q, 0);
    chk("postreset_no_done", seen_done, 0);

    // randomized operations against the arithmetic model
    mq = 8'h00;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] r_op;
      logic [3:0] r_cnt;
      logic [7:0] r_ld;
      logic       r_sl, r_sr;
      r_op  = 3'($urandom_range(0, 7));
      r_cnt = 4'($urandom_range(0, 15));
      r_ld  = 8'($urandom);
      r_sl  = 1'($urandom);
      r_sr  = 1'($urandom);
      run_op(r_op, r_cnt, r_ld, r_sl, r_sr, q_got, lat, bcyc);
      exp_q = m_apply(mq, r_op, int'(r_cnt), r_ld, r_sl, r_sr);
      chk("rand_q", q_got, exp_q);
      chk("rand_lat", lat, m_lat(r_op, int'(r_cnt)));
      chk("rand_busy_cycles", bcyc, m_lat(r_op, int'(r_cnt)) - 1);
      chk("rand_ser_out_l", bus.ser_out_l, exp_q[7]);
      chk("rand_ser_out_r", bus.ser_out_r, exp_q[0]);
      mq = exp_q;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
